mac_job_sched: RTL and testbench

- Round-robin scheduler that shares one 4x4 multiply-accumulate datapath between two requesters.
- Each requester streams a dot-product job as operand pairs (A,B) over a valid/ready handshake, with a last flag on the final pair.
- The block sequences the datapath, first product loading and later products accumulating, and returns the 8-bit result with the requester ID over a valid/ready result port.
- It sits between the two operand sources and the arithmetic core.

---
 rtl/mac_job_sched.sv | 141 ++++++++++++++
 tb/tb_mac_job_sched.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_job_sched.sv
// mac_job_sched: round-robin sharing of one OPW x OPW multiply-accumulate between two requesters; result 1 cycle after last accept.
// res_ready low holds DONE with both req_ready low; MAC_SAT_EN selects saturating accumulation (default wraps).
module mac_job_sched #(
    parameter int OPW  = 4,
    parameter int ACCW = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [OPW-1:0]  req0_a,
    input  logic [OPW-1:0]  req0_b,
    input  logic            req0_last,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [OPW-1:0]  req1_a,
    input  logic [OPW-1:0]  req1_b,
    input  logic            req1_last,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [ACCW-1:0] res_data,
    output logic            res_id,
    output logic            res_sat,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic            grant_q, grant_d;
    logic            last_srv_q, last_srv_d;
    logic            first_q, first_d;
    logic [ACCW-1:0] acc_q, acc_d;

    logic            fire_w;
    logic            last_w;
    logic [OPW-1:0]  op_a_w;
    logic [OPW-1:0]  op_b_w;
    logic [ACCW-1:0] prod_w;

    // Operand path is steered purely by the registered grant.
    assign op_a_w = grant_q ? req1_a : req0_a;
    assign op_b_w = grant_q ? req1_b : req0_b;
    assign last_w = grant_q ? req1_last : req0_last;
    assign fire_w = (state_q == RUN) && (grant_q ? req1_valid : req0_valid);
    assign prod_w = ACCW'(op_a_w) * ACCW'(op_b_w);

`ifdef MAC_SAT_EN
    logic            sat_q, sat_d;
    logic [ACCW:0]   sum_w;
    assign sum_w   = {1'b0, acc_q} + {1'b0, prod_w};
    assign res_sat = sat_q;
`else
    logic [ACCW-1:0] sum_w;
    assign sum_w   = acc_q + prod_w;
    assign res_sat = 1'b0;
`endif

    assign req0_ready = (state_q == RUN) && !grant_q;
    assign req1_ready = (state_q == RUN) && grant_q;
    assign res_valid  = (state_q == DONE);
    assign res_data   = acc_q;
    assign res_id     = grant_q;
    assign busy       = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_srv_d = last_srv_q;
        first_d    = first_q;
        acc_d      = acc_q;
`ifdef MAC_SAT_EN
        sat_d      = sat_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    // On a tie the requester not served last wins.
                    grant_d = (req0_valid && req1_valid) ? ~last_srv_q : req1_valid;
                    first_d = 1'b1;
                    state_d = RUN;
`ifdef MAC_SAT_EN
                    sat_d   = 1'b0;
`endif
                end
            end
            RUN: begin
                if (fire_w) begin
                    if (first_q) begin
                        acc_d = prod_w;
                    end else begin
`ifdef MAC_SAT_EN
                        if (sum_w[ACCW]) begin
                            acc_d = '1;
                            sat_d = 1'b1;
                        end else begin
                            acc_d = sum_w[ACCW-1:0];
                        end
`else
                        acc_d = sum_w;
`endif
                    end
                    first_d = 1'b0;
                    if (last_w) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (res_ready) begin
                    last_srv_d = grant_q;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            last_srv_q <= 1'b1;
            first_q    <= 1'b0;
            acc_q      <= '0;
`ifdef MAC_SAT_EN
            sat_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_srv_q <= last_srv_d;
            first_q    <= first_d;
            acc_q      <= acc_d;
`ifdef MAC_SAT_EN
            sat_q      <= sat_d;
`endif
        end
    end

endmodule

// File: tb/tb_mac_job_sched.sv
// Directed bench for mac_job_sched: arbitration, accumulation, backpressure, reset and stream gaps.
module tb_mac_job_sched;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       req0_valid = 1'b0, req0_last = 1'b0;
    logic [3:0] req0_a = 4'd0, req0_b = 4'd0;
    logic       req1_valid = 1'b0, req1_last = 1'b0;
    logic [3:0] req1_a = 4'd0, req1_b = 4'd0;
    logic       req0_ready, req1_ready;
    logic       res_valid, res_id, res_sat, busy;
    logic       res_ready = 1'b0;
    logic [7:0] res_data;

    int passed = 0;
    int total  = 0;

    mac_job_sched dut (
        .CLK        (CLK),
        .RST        (RST),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_last  (req0_last),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_last  (req1_last),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .res_sat    (res_sat),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic r0(input logic v, input logic [3:0] a, input logic [3:0] b, input logic l);
        req0_valid = v; req0_a = a; req0_b = b; req0_last = l;
    endtask

    task automatic r1(input logic v, input logic [3:0] a, input logic [3:0] b, input logic l);
        req1_valid = v; req1_a = a; req1_b = b; req1_last = l;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while RST is held.
        #3;
        chk("rst_busy",  8'(busy),       8'd0);
        chk("rst_rdy0",  8'(req0_ready), 8'd0);
        chk("rst_rdy1",  8'(req1_ready), 8'd0);
        chk("rst_valid", 8'(res_valid),  8'd0);
        chk("rst_data",  res_data,       8'd0);
        chk("rst_id",    8'(res_id),     8'd0);
        chk("rst_sat",   8'(res_sat),    8'd0);
        tick();
        tick();
        RST = 1'b0;
        res_ready = 1'b1;

        // Tie right after reset: req0 first, then req0 loses the next tie.
        r0(1'b1, 4'd2, 4'd3, 1'b1);
        r1(1'b1, 4'd4, 4'd5, 1'b1);
        tick();
        chk("tie_rdy0", 8'(req0_ready), 8'd1);
        chk("tie_rdy1", 8'(req1_ready), 8'd0);
        tick();
        r0(1'b1, 4'd1, 4'd1, 1'b1);
        chk("tie_v0",    8'(res_valid),  8'd1);
        chk("tie_d0",    res_data,       8'd6);
        chk("tie_id0",   8'(res_id),     8'd0);
        chk("tie_r1lck", 8'(req1_ready), 8'd0);
        tick();
        chk("tie_hs_v",  8'(res_valid),  8'd0);
        chk("tie_hs_r1", 8'(req1_ready), 8'd0);
        tick();
        chk("tie2_rdy1", 8'(req1_ready), 8'd1);
        chk("tie2_rdy0", 8'(req0_ready), 8'd0);
        tick();
        r1(1'b0, 4'd0, 4'd0, 1'b0);
        chk("tie2_d",  res_data,   8'd20);
        chk("tie2_id", 8'(res_id), 8'd1);
        tick();
        tick();
        chk("tie3_rdy0", 8'(req0_ready), 8'd1);
        tick();
        r0(1'b0, 4'd0, 4'd0, 1'b0);
        chk("tie3_d",  res_data,   8'd1);
        chk("tie3_id", 8'(res_id), 8'd0);
        tick();

        // Basic two-pair job: 3*4 + 5*6 = 42.
        r0(1'b1, 4'd3, 4'd4, 1'b0);
        tick();
        chk("bas_rdy0", 8'(req0_ready), 8'd1);
        chk("bas_busy", 8'(busy),       8'd1);
        tick();
        r0(1'b1, 4'd5, 4'd6, 1'b1);
        chk("bas_v_mid", 8'(res_valid), 8'd0);
        tick();
        r0(1'b0, 4'd0, 4'd0, 1'b0);
        chk("bas_v",    8'(res_valid),  8'd1);
        chk("bas_d",    res_data,       8'd42);
        chk("bas_id",   8'(res_id),     8'd0);
        chk("bas_rdy",  8'(req0_ready), 8'd0);
        tick();
        chk("bas_busy_end", 8'(busy),      8'd0);
        chk("bas_v_end",    8'(res_valid), 8'd0);

        // Wrap/saturate: 225 + 225.
        r1(1'b1, 4'd15, 4'd15, 1'b0);
        tick();
        tick();
        r1(1'b1, 4'd15, 4'd15, 1'b1);
        tick();
        r1(1'b0, 4'd0, 4'd0, 1'b0);
        chk("wrp_id", 8'(res_id), 8'd1);
`ifdef MAC_SAT_EN
        chk("wrp_d",   res_data,    8'd255);
        chk("wrp_sat", 8'(res_sat), 8'd1);
`else
        chk("wrp_d",   res_data,    8'd194);
        chk("wrp_sat", 8'(res_sat), 8'd0);
`endif
        tick();

        // Backpressure: result held 5 cycles while req0 waits.
        res_ready = 1'b0;
        r1(1'b1, 4'd3, 4'd3, 1'b1);
        tick();
        tick();
        r1(1'b0, 4'd0, 4'd0, 1'b0);
        r0(1'b1, 4'd6, 4'd7, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_v",    8'(res_valid),  8'd1);
            chk("bp_d",    res_data,       8'd9);
            chk("bp_id",   8'(res_id),     8'd1);
            chk("bp_rdy0", 8'(req0_ready), 8'd0);
            chk("bp_rdy1", 8'(req1_ready), 8'd0);
            tick();
        end
        chk("bp_v_end", 8'(res_valid), 8'd1);
        res_ready = 1'b1;
        tick();
        chk("bp_hs_v", 8'(res_valid), 8'd0);
        tick();
        chk("bp_g0", 8'(req0_ready), 8'd1);
        tick();
        r0(1'b0, 4'd0, 4'd0, 1'b0);
        chk("bp_d2",  res_data,   8'd42);
        chk("bp_id2", 8'(res_id), 8'd0);
        tick();

        // Reset mid-job, then a fresh single-pair job.
        r0(1'b1, 4'd1, 4'd2, 1'b0);
        tick();
        tick();
        RST = 1'b1;
        r0(1'b0, 4'd0, 4'd0, 1'b0);
        #1;
        chk("mr_busy",  8'(busy),       8'd0);
        chk("mr_rdy0",  8'(req0_ready), 8'd0);
        chk("mr_valid", 8'(res_valid),  8'd0);
        chk("mr_data",  res_data,       8'd0);
        chk("mr_id",    8'(res_id),     8'd0);
        tick();
        RST = 1'b0;
        r0(1'b1, 4'd2, 4'd7, 1'b1);
        tick();
        chk("mr_nov", 8'(res_valid), 8'd0);
        tick();
        r0(1'b0, 4'd0, 4'd0, 1'b0);
        chk("mr_d2", res_data, 8'd14);
        tick();

        // Stream gap: req0 keeps the lock while req1 waits.
        r0(1'b1, 4'd1, 4'd1, 1'b0);
        tick();
        r1(1'b1, 4'd4, 4'd4, 1'b1);
        tick();
        r0(1'b0, 4'd0, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("gap_rdy0", 8'(req0_ready), 8'd1);
            chk("gap_rdy1", 8'(req1_ready), 8'd0);
            chk("gap_v",    8'(res_valid),  8'd0);
        end
        r0(1'b1, 4'd2, 4'd2, 1'b1);
        tick();
        r0(1'b0, 4'd0, 4'd0, 1'b0);
        chk("gap_d",  res_data,   8'd5);
        chk("gap_id", 8'(res_id), 8'd0);
        tick();
        tick();
        chk("gap_r1", 8'(req1_ready), 8'd1);
        tick();
        r1(1'b0, 4'd0, 4'd0, 1'b0);
        chk("gap_d1",  res_data,   8'd16);
        chk("gap_id1", 8'(res_id), 8'd1);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
